piezo_sound_sched: RTL and testbench

- Shares the single PIEZO_SPEAKER output between four game-event sound requesters: 0 = hit, 1 = miss, 2 = level-up, 3 = super mode.
- Latches one-cycle request pulses and grants the highest pending index.
- Plays the granted sound as a fixed-priority beep train: N beeps of a square tone, separated by silent gaps.
- A higher-priority request preempts a lower one. Sits between the ball/score logic and the speaker pin.

---
 rtl/piezo_sound_sched.sv | 186 ++++++++++++++++++
 tb/tb_piezo_sound_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_sound_sched.sv
// Arbitrates four game-event sound requests onto one piezo pin and plays the
// granted sound as a beep train of square-wave tone bursts.
module piezo_sound_sched #(
    parameter int CNT_W   = 26,
    parameter int ON_CYC  = 20000000,
    parameter int OFF_CYC = 10000000,
    parameter int HP0     = 262144,
    parameter int HP1     = 1048576,
    parameter int HP2     = 131072,
    parameter int HP3     = 262144,
    parameter int BEEPS0  = 1,
    parameter int BEEPS1  = 1,
    parameter int BEEPS2  = 2,
    parameter int BEEPS3  = 4
) (
    input  logic       USER_CLK,
    input  logic       GPIO_SW_C,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done,
    output logic [1:0] done_id,
    output logic       PIEZO_SPEAKER
);

    localparam int NUM_SND = 4;

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t             state, state_n;
    logic [NUM_SND-1:0] pending, pending_n;
    logic [1:0]         act_id, act_id_n;
    logic [3:0]         beeps_left, beeps_left_n;
    logic [CNT_W-1:0]   dur, dur_n;
    logic [CNT_W-1:0]   tone, tone_n;
    logic               spk, spk_n;
    logic               done_r, done_n;
    logic [1:0]         done_id_r, done_id_n;

    logic [1:0]         win_id;
    logic               has_pend;
    logic               preempt;
    logic               load;

    function automatic logic [CNT_W-1:0] hp_of(input logic [1:0] id);
        case (id)
            2'd0:    return CNT_W'(HP0);
            2'd1:    return CNT_W'(HP1);
            2'd2:    return CNT_W'(HP2);
            default: return CNT_W'(HP3);
        endcase
    endfunction

    function automatic logic [3:0] beeps_of(input logic [1:0] id);
        case (id)
            2'd0:    return 4'(BEEPS0);
            2'd1:    return 4'(BEEPS1);
            2'd2:    return 4'(BEEPS2);
            default: return 4'(BEEPS3);
        endcase
    endfunction

    // Fixed priority: the highest set pending bit wins.
    always_comb begin
        win_id = 2'd0;
        for (int i = 0; i < NUM_SND; i++)
            if (pending[i]) win_id = 2'(i);
    end

    assign has_pend = |pending;

    always_comb begin
        preempt = 1'b0;
        if (state != IDLE)
            for (int i = 0; i < NUM_SND; i++)
                if (pending[i] && (i > int'(act_id))) preempt = 1'b1;
    end

    // A fresh request on the granting edge survives, so the sound replays.
    for (genvar i = 0; i < NUM_SND; i++) begin : g_pend
        assign pending_n[i] = req[i] | (pending[i] & ~(load && (win_id == 2'(i))));
    end

    always_comb begin
        state_n      = state;
        act_id_n     = act_id;
        beeps_left_n = beeps_left;
        dur_n        = dur;
        tone_n       = tone;
        spk_n        = spk;
        done_n       = 1'b0;
        done_id_n    = done_id_r;
        load         = 1'b0;

        case (state)
            IDLE: begin
                spk_n = 1'b0;
                if (has_pend) load = 1'b1;
            end
            ON: begin
                if (preempt) begin
                    load = 1'b1;
                end else begin
                    dur_n = dur + 1'b1;
                    if (tone == hp_of(act_id) - 1'b1) begin
                        tone_n = '0;
                        spk_n  = ~spk;
                    end else begin
                        tone_n = tone + 1'b1;
                    end
                    if (dur == CNT_W'(ON_CYC - 1)) begin
                        dur_n  = '0;
                        tone_n = '0;
                        spk_n  = 1'b0;
                        if (beeps_left == 4'd1) begin
                            state_n   = IDLE;
                            done_n    = 1'b1;
                            done_id_n = act_id;
                        end else begin
                            state_n      = OFF;
                            beeps_left_n = beeps_left - 1'b1;
                        end
                    end
                end
            end
            OFF: begin
                spk_n = 1'b0;
                if (preempt) begin
                    load = 1'b1;
                end else begin
                    dur_n = dur + 1'b1;
                    if (dur == CNT_W'(OFF_CYC - 1)) begin
                        state_n = ON;
                        dur_n   = '0;
                        tone_n  = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                spk_n   = 1'b0;
            end
        endcase

        // Grant from idle and preemption both start the winner with fresh counters.
        if (load) begin
            state_n      = ON;
            act_id_n     = win_id;
            beeps_left_n = beeps_of(win_id);
            dur_n        = '0;
            tone_n       = '0;
            spk_n        = 1'b0;
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (GPIO_SW_C) begin
            state      <= IDLE;
            pending    <= '0;
            act_id     <= 2'd0;
            beeps_left <= 4'd0;
            dur        <= '0;
            tone       <= '0;
            spk        <= 1'b0;
            done_r     <= 1'b0;
            done_id_r  <= 2'd0;
        end else begin
            state      <= state_n;
            pending    <= pending_n;
            act_id     <= act_id_n;
            beeps_left <= beeps_left_n;
            dur        <= dur_n;
            tone       <= tone_n;
            spk        <= spk_n;
            done_r     <= done_n;
            done_id_r  <= done_id_n;
        end
    end

    assign busy          = (state != IDLE);
    assign grant         = busy ? (4'b0001 << act_id) : 4'b0000;
    assign done          = done_r;
    assign done_id       = done_id_r;
    assign PIEZO_SPEAKER = spk;

endmodule

// File: tb/tb_piezo_sound_sched.sv
// Cycle-exact scoreboard bench: each scenario queues the expected per-cycle
// {grant, busy, done, done_id, speaker} trace, then pops it as the DUT runs.
module tb_piezo_sound_sched;

    logic       USER_CLK = 1'b0;
    logic       GPIO_SW_C;
    logic [3:0] req;
    logic [3:0] grant;
    logic       busy;
    logic       done;
    logic [1:0] done_id;
    logic       PIEZO_SPEAKER;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] exp_q[$];
    logic [8:0] exp_v;
    logic [8:0] obs;

    localparam int ON_CYC  = 8;
    localparam int OFF_CYC = 4;

    piezo_sound_sched #(
        .CNT_W(26), .ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC),
        .HP0(2), .HP1(1048576), .HP2(131072), .HP3(1),
        .BEEPS0(1), .BEEPS1(1), .BEEPS2(2), .BEEPS3(3)
    ) dut (
        .USER_CLK(USER_CLK),
        .GPIO_SW_C(GPIO_SW_C),
        .req(req),
        .grant(grant),
        .busy(busy),
        .done(done),
        .done_id(done_id),
        .PIEZO_SPEAKER(PIEZO_SPEAKER)
    );

    always #5 USER_CLK = ~USER_CLK;

    function automatic logic [8:0] rec(input logic [3:0] g, input logic b, input logic d,
                                       input logic [1:0] id, input logic s);
        return {g, b, d, id, s};
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(rec(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0));
    endtask

    // On-phase cycle j (0 = cycle after entry) shows speaker = floor(j/hp) mod 2.
    task automatic push_on(input int id, input int hp, input int n);
        for (int j = 0; j < n; j++)
            exp_q.push_back(rec(4'b0001 << id, 1'b1, 1'b0, 2'd0, ((j / hp) % 2) == 1));
    endtask

    task automatic push_sound(input int id, input int hp, input int beeps);
        for (int b = 0; b < beeps; b++) begin
            push_on(id, hp, ON_CYC);
            if (b < beeps - 1)
                for (int j = 0; j < OFF_CYC; j++)
                    exp_q.push_back(rec(4'b0001 << id, 1'b1, 1'b0, 2'd0, 1'b0));
        end
        exp_q.push_back(rec(4'b0000, 1'b0, 1'b1, 2'(id), 1'b0));
    endtask

    task automatic test_reset();
        GPIO_SW_C = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(posedge USER_CLK); #1;
            obs = {grant, busy, done, done_id, PIEZO_SPEAKER};
            vectors++;
            if (obs !== 9'd0) begin
                miscompares++;
                $display("FAIL reset c=%0d got=%b want=%b", c, obs, 9'd0);
            end
        end
        @(negedge USER_CLK);
        GPIO_SW_C = 1'b0;
        req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(posedge USER_CLK); #1;
            obs = {grant, busy, done, done_id, PIEZO_SPEAKER};
            vectors++;
            if (obs !== 9'd0) begin
                miscompares++;
                $display("FAIL reset_release c=%0d got=%b want=%b", c, obs, 9'd0);
            end
        end
    endtask

    task automatic test_single();
        int n;
        exp_q.delete();
        push_idle(1); push_sound(0, 2, 1); push_idle(2);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge USER_CLK);
            req = (c == 0) ? 4'b0001 : 4'b0000;
            @(posedge USER_CLK); #1;
            exp_v = exp_q.pop_front();
            obs = {grant, busy, done, done ? done_id : 2'b00, PIEZO_SPEAKER};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL single c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_same_cycle();
        int n;
        exp_q.delete();
        push_idle(1); push_sound(1, 1048576, 1); push_sound(0, 2, 1); push_idle(2);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge USER_CLK);
            req = (c == 0) ? 4'b0011 : 4'b0000;
            @(posedge USER_CLK); #1;
            exp_v = exp_q.pop_front();
            obs = {grant, busy, done, done ? done_id : 2'b00, PIEZO_SPEAKER};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL same_cycle c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_self_replay();
        int n;
        exp_q.delete();
        push_idle(1); push_sound(0, 2, 1); push_sound(0, 2, 1); push_idle(3);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge USER_CLK);
            req = (c == 0 || c == 3) ? 4'b0001 : 4'b0000;
            @(posedge USER_CLK); #1;
            exp_v = exp_q.pop_front();
            obs = {grant, busy, done, done ? done_id : 2'b00, PIEZO_SPEAKER};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL self_replay c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    // Request held across the granting edge: set beats clear, one replay.
    task automatic test_back_to_back();
        int n;
        exp_q.delete();
        push_idle(1); push_sound(0, 2, 1); push_sound(0, 2, 1); push_idle(3);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge USER_CLK);
            req = (c <= 1) ? 4'b0001 : 4'b0000;
            @(posedge USER_CLK); #1;
            exp_v = exp_q.pop_front();
            obs = {grant, busy, done, done ? done_id : 2'b00, PIEZO_SPEAKER};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_multi_beep();
        int n;
        exp_q.delete();
        push_idle(1); push_sound(3, 1, 3); push_idle(2);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge USER_CLK);
            req = (c == 0) ? 4'b1000 : 4'b0000;
            @(posedge USER_CLK); #1;
            exp_v = exp_q.pop_front();
            obs = {grant, busy, done, done ? done_id : 2'b00, PIEZO_SPEAKER};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL multi_beep c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_preempt();
        int n;
        exp_q.delete();
        push_idle(1); push_on(0, 2, 4); push_sound(3, 1, 3); push_idle(6);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge USER_CLK);
            req = (c == 0) ? 4'b0001 : (c == 4) ? 4'b1000 : 4'b0000;
            @(posedge USER_CLK); #1;
            exp_v = exp_q.pop_front();
            obs = {grant, busy, done, done ? done_id : 2'b00, PIEZO_SPEAKER};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL preempt c=%0d got=%b want=%b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        exp_q.delete();
        push_idle(1); push_on(3, 1, 5); push_idle(25);
        n = exp_q.size();
        for (int c = 0; c < n; c++) begin
            @(negedge USER_CLK);
            req = (c == 0) ? 4'b1000 : (c == 3) ? 4'b0010 : 4'b0000;
            GPIO_SW_C = (c == 6);
            @(posedge USER_CLK); #1;
            exp_v = exp_q.pop_front();
            obs = {grant, busy, done, done ? done_id : 2'b00, PIEZO_SPEAKER};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_mid c=%0d got=%b want=%b", c, obs, exp_v);
            end
            if (c == 6) begin
                vectors++;
                if (done_id !== 2'd0) begin
                    miscompares++;
                    $display("FAIL reset_mid_done_id got=%0d want=0", done_id);
                end
            end
        end
        GPIO_SW_C = 1'b0;
    endtask

    initial begin
        GPIO_SW_C = 1'b1;
        req = 4'b0000;
        test_reset();
        test_single();
        test_same_cycle();
        test_self_replay();
        test_back_to_back();
        test_multi_beep();
        test_preempt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
